uart_param: RTL
===============

# uart_param

Parametrised single-clock UART with a programmable baud divider, configurable frame format (data bits, parity, stop bits) and a first-word-fall-through receive FIFO. It succeeds the fixed 8N1 dual-clock UART: both directions now run on one system clock gated by a shared 16x oversampling tick. RX error reporting covers framing, parity and overrun. It sits between the system-side register interface and the serial pins.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: stop bits transmitted, legal 1 or 2.
- `CLK_DIV`, default 27: system clocks per 16x oversampling tick, legal ≥1.
- `RX_DEPTH`, default 4: RX FIFO entries, power of two, ≥2.
- `clk` input 1: single system clock; all logic is rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `ld_tx_data` input 1: load request for the TX holding register.
- `tx_data` input DATA_BITS: word to transmit, sampled on an accepted load.
- `tx_enable` input 1: permits new TX frames to start.
- `tx_out` output 1: serial TX line, idles high.
- `tx_empty` output 1: TX holding register and shifter are both free.
- `rx_in` input 1: serial RX line, asynchronous to `clk`.
- `rx_enable` input 1: enables the receiver.
- `uld_rx_data` input 1: pop request for the RX FIFO head.
- `rx_data` output DATA_BITS: RX FIFO head word.
- `rx_empty` output 1: RX FIFO is empty.
- `rx_level` output $clog2(RX_DEPTH+1): number of RX FIFO entries.
- `rx_frame_err` output 1: head entry's stop bit was sampled 0.
- `rx_parity_err` output 1: head entry failed the parity check. Always 0 when PARITY=0.
- `rx_overrun` output 1: sticky flag, set when a frame was dropped on a full FIFO.

## Operation
- Reset values: `tx_out`=1, `tx_empty`=1, `rx_data`=0, `rx_empty`=1, `rx_level`=0, all three error flags 0. Reset also sets the tick counter, both FSMs and the FIFO pointers to 0/IDLE.
- Tick generator: free-running counter 0..CLK_DIV-1. `tick` pulses for one clock when the count equals CLK_DIV-1, then the counter wraps to 0.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - A load is accepted only when `ld_tx_data`=1, `tx_empty`=1 and `tx_enable`=1. Requests under any other condition are ignored.
  - After an accepted load, `tx_empty` goes 0 on the next clock.
  - At the next `tick` the FSM enters START and drives `tx_out` low for 16 ticks.
  - DATA sends DATA_BITS bits, LSB first, 16 ticks each.
  - PARITY (skipped when PARITY=0) sends the XOR of the data bits for even parity, or its inverse for odd parity.
  - STOP drives 1 for 16×STOP_BITS ticks. When STOP ends, the FSM returns to IDLE and `tx_empty` returns to 1.
  - Dropping `tx_enable` mid-frame does not abort the frame.
- RX front end: a 2-flop synchronizer on `rx_in` feeds the FSM.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a synchronized low seen at a tick.
  - In START, the line is sampled on the 8th tick (mid-bit). If it is high, the start is false and the FSM returns to IDLE.
  - Each later bit is sampled 16 ticks after the previous sample.
  - Only the first stop bit is checked. At that sample, {data, frame_err, parity_err} is written to the FIFO and the FSM returns to IDLE.
  - `rx_enable`=0 forces the FSM to IDLE and discards any partial frame. FIFO contents are kept.
- RX FIFO behaviour:
  - First-word fall-through: `rx_data` and both per-entry error flags show the head entry.
  - While the FIFO is empty, `rx_data` holds its last value and the error flags read 0.
  - `uld_rx_data` with `rx_empty`=0 pops the head. A pop on an empty FIFO is ignored.
  - A write to a full FIFO drops the frame and sets `rx_overrun`. `rx_overrun` clears on the next accepted pop.
  - A push and a pop in the same clock are both honoured, and `rx_level` is unchanged.
  - Pointers wrap modulo RX_DEPTH.

## Timing
- Bit period = 16×CLK_DIV clocks.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) bit periods.
- TX latency: `tx_out` falls at the first tick at least 1 clock after load acceptance, i.e. within CLK_DIV+1 clocks.
- RX latency: `rx_empty` falls 1 clock after the stop-bit mid-sample, which is about 2.5 clocks plus half a bit after the stop bit's leading edge on the pin.
- Pop: `rx_level` and the head advance 1 clock after `uld_rx_data`.
- Reset mid-frame: `tx_out` goes to 1 immediately (asynchronously) and both frames are lost.

## Test plan
- CLK_DIV=1, 8N1: load 0xA5 → `tx_out` shows 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks, and `tx_empty` rises 160 clocks after the start edge.
- Loopback `tx_out`→`rx_in`, PARITY=2: send 0x3C → `rx_data`=0x3C, `rx_parity_err`=0, `rx_frame_err`=0, `rx_level`=1; pop → `rx_empty`=1.
- Drive 0x55 with a wrong parity bit, then 0x0F with stop=0 → entry 1 has `rx_parity_err`=1; entry 2 has `rx_frame_err`=1 and `rx_data`=0x0F.
- RX_DEPTH=4: receive 5 frames with no pop → `rx_level`=4, `rx_overrun`=1, head is frame 1; one pop → `rx_overrun`=0, `rx_level`=3.
- Drive a 4-tick low glitch on `rx_in` → no FIFO write, FSM back in IDLE. Assert `ld_tx_data` while `tx_empty`=0 → word ignored, current frame unchanged.
- Assert `reset_n`=0 during a TX data bit → `tx_out`=1 and `tx_empty`=1 at once; after release, a new load transmits normally.

Source files
------------

// File: rtl/uart_param_if.sv
// rtl/uart_param_if.sv - system-side register/handshake bundle for uart_param
//
// master: system side (loads TX words, pops RX words, reads status)
// slave : the UART
//   ld_tx_data/tx_data/tx_enable/tx_empty        : TX holding register load
//   rx_enable/uld_rx_data/rx_data/rx_empty        : RX FIFO pop and head word
//   rx_level/rx_frame_err/rx_parity_err/rx_overrun: RX FIFO status
interface uart_param_if #(
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 4
);
    localparam int LW = $clog2(RX_DEPTH + 1);

    logic                 ld_tx_data;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_enable;
    logic                 tx_empty;
    logic                 rx_enable;
    logic                 uld_rx_data;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_empty;
    logic [LW-1:0]        rx_level;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_overrun;

    modport master (
        output ld_tx_data, tx_data, tx_enable, rx_enable, uld_rx_data,
        input  tx_empty, rx_data, rx_empty, rx_level,
               rx_frame_err, rx_parity_err, rx_overrun
    );

    modport slave (
        input  ld_tx_data, tx_data, tx_enable, rx_enable, uld_rx_data,
        output tx_empty, rx_data, rx_empty, rx_level,
               rx_frame_err, rx_parity_err, rx_overrun
    );
endinterface

// File: rtl/uart_param.sv
// rtl/uart_param.sv - single-clock parametrised UART with FWFT receive FIFO
//
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : uart_param_if.slave, system-side load/pop/status signals
//   tx_out  : serial transmit line, idles high
//   rx_in   : serial receive line, asynchronous to clk
module uart_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CLK_DIV   = 27,
    parameter int RX_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    uart_param_if.slave  bus,
    output logic         tx_out,
    input  logic         rx_in
);
    localparam int   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int   AW      = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int   LW      = $clog2(RX_DEPTH + 1);
    localparam int   EW      = DATA_BITS + 2;
    localparam logic HAS_PAR = (PARITY != 0);
    localparam logic PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // 16x oversampling tick shared by both directions
    logic [CW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= tick ? '0 : div_q + 1'b1;
    end

    // ------------------------------------------------------------------ TX
    state_t               tx_state_q;
    logic [3:0]           tx_tcnt_q;
    logic [3:0]           tx_bcnt_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic                 tx_out_q;
    logic                 tx_empty_q;
    logic                 tx_accept;

    assign tx_accept = bus.ld_tx_data & tx_empty_q & bus.tx_enable;

    // tx_empty_q=0 while in IDLE means a word is waiting for the next tick.
    // tx_tcnt_q counts ticks within a bit and wraps 15->0 on its own.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= S_IDLE;
            tx_tcnt_q  <= '0;
            tx_bcnt_q  <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
            tx_empty_q <= 1'b1;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    if (tx_accept) begin
                        tx_shift_q <= bus.tx_data;
                        tx_par_q   <= (^bus.tx_data) ^ PAR_ODD;
                        tx_empty_q <= 1'b0;
                    end else if (!tx_empty_q && tick) begin
                        tx_state_q <= S_START;
                        tx_out_q   <= 1'b0;
                        tx_tcnt_q  <= '0;
                    end
                end
                default: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 1'b1;
                        if (tx_tcnt_q == 4'd15) begin
                            case (tx_state_q)
                                S_START: begin
                                    tx_state_q <= S_DATA;
                                    tx_out_q   <= tx_shift_q[0];
                                    tx_bcnt_q  <= '0;
                                end
                                S_DATA: begin
                                    if (tx_bcnt_q == 4'(DATA_BITS - 1)) begin
                                        tx_bcnt_q <= '0;
                                        if (HAS_PAR) begin
                                            tx_state_q <= S_PARITY;
                                            tx_out_q   <= tx_par_q;
                                        end else begin
                                            tx_state_q <= S_STOP;
                                            tx_out_q   <= 1'b1;
                                        end
                                    end else begin
                                        tx_shift_q <= tx_shift_q >> 1;
                                        tx_out_q   <= tx_shift_q[1];
                                        tx_bcnt_q  <= tx_bcnt_q + 1'b1;
                                    end
                                end
                                S_PARITY: begin
                                    tx_state_q <= S_STOP;
                                    tx_out_q   <= 1'b1;
                                    tx_bcnt_q  <= '0;
                                end
                                S_STOP: begin
                                    if (tx_bcnt_q == 4'(STOP_BITS - 1)) begin
                                        tx_state_q <= S_IDLE;
                                        tx_empty_q <= 1'b1;
                                    end else begin
                                        tx_bcnt_q <= tx_bcnt_q + 1'b1;
                                    end
                                end
                                default: tx_state_q <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign tx_out       = tx_out_q;
    assign bus.tx_empty = tx_empty_q;

    // ------------------------------------------------------------------ RX
    logic                 rx_s1_q, rx_s2_q;
    state_t               rx_state_q;
    logic [3:0]           rx_tcnt_q;
    logic [3:0]           rx_bcnt_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_q;
    logic                 push_q;
    logic [EW-1:0]        wdata_q;

    // Synchronizer resets high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_in;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q <= S_IDLE;
            rx_tcnt_q  <= '0;
            rx_bcnt_q  <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            push_q     <= 1'b0;
            wdata_q    <= '0;
        end else begin
            push_q <= 1'b0;
            if (!bus.rx_enable) begin
                rx_state_q <= S_IDLE;
            end else if (tick) begin
                case (rx_state_q)
                    S_IDLE: begin
                        if (!rx_s2_q) begin
                            rx_state_q <= S_START;
                            rx_tcnt_q  <= '0;
                        end
                    end
                    S_START: begin
                        // mid-bit check rejects glitches shorter than half a bit
                        if (rx_tcnt_q == 4'd7) begin
                            rx_tcnt_q <= '0;
                            rx_bcnt_q <= '0;
                            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_shift_q <= {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                            if (rx_bcnt_q == 4'(DATA_BITS - 1))
                                rx_state_q <= HAS_PAR ? S_PARITY : S_STOP;
                            else
                                rx_bcnt_q <= rx_bcnt_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_par_q   <= rx_s2_q;
                            rx_state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        rx_tcnt_q <= rx_tcnt_q + 1'b1;
                        if (rx_tcnt_q == 4'd15) begin
                            push_q     <= 1'b1;
                            wdata_q    <= {HAS_PAR & (((^rx_shift_q) ^ rx_par_q) != PAR_ODD),
                                           ~rx_s2_q, rx_shift_q};
                            rx_state_q <= S_IDLE;
                        end
                    end
                    default: rx_state_q <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ RX FIFO
    // Entry layout: {parity_err, frame_err, data}
    logic [EW-1:0]        mem_q [RX_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        count_q;
    logic [DATA_BITS-1:0] last_q;
    logic                 ovr_q;
    logic                 empty, full, pop, wr;
    logic [EW-1:0]        head;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(RX_DEPTH));
    assign pop   = bus.uld_rx_data & ~empty;
    assign wr    = push_q & (~full | pop);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= wdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // shadow of the head so rx_data holds its last value once drained
            if (!empty) last_q <= head[DATA_BITS-1:0];
            if (pop)                ovr_q <= 1'b0;
            else if (push_q && full) ovr_q <= 1'b1;
        end
    end

    assign bus.rx_empty      = empty;
    assign bus.rx_level      = count_q;
    assign bus.rx_overrun    = ovr_q;
    assign bus.rx_data       = empty ? last_q : head[DATA_BITS-1:0];
    assign bus.rx_frame_err  = ~empty & head[DATA_BITS];
    assign bus.rx_parity_err = ~empty & head[DATA_BITS+1];
endmodule
